// File: rtl/adder_result_accumulator_pkg.sv
// Shared types and width defaults for the adder result accumulator.
package adder_result_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int ADD_RES_WIDTH = 13;
    localparam int ACC_WIDTH_DEF = 20;
    localparam int CNT_WIDTH_DEF = 4;

endpackage

// File: rtl/adder_result_accumulator_sat_adder_acc.sv
// Combinational saturating add of an unsigned sample into the running total.
module sat_adder_acc #(
    parameter int IN_WIDTH  = 13,
    parameter int ACC_WIDTH = 20
) (
    input  logic [ACC_WIDTH-1:0] i_acc,
    input  logic [IN_WIDTH-1:0]  i_data,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_sat
);

    logic [ACC_WIDTH:0] full_sum;

    always_comb begin
        full_sum = {1'b0, i_acc} + (ACC_WIDTH + 1)'(i_data);
        o_sat    = full_sum[ACC_WIDTH];
        o_sum    = o_sat ? '1 : full_sum[ACC_WIDTH-1:0];
    end

endmodule

// File: rtl/adder_result_accumulator.sv
// Sums a programmable number of adder results per frame and presents the
// saturating frame total on a registered valid/ready output.
module adder_result_accumulator
    import adder_result_accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = ADD_RES_WIDTH,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic [CNT_WIDTH-1:0] i_frame_len,
    input  logic                 i_clear,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_overflow,
    output logic                 o_busy
);

    state_e                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic                  ovf_q, ovf_d;
    logic                  valid_q, valid_d;
    logic [ACC_WIDTH-1:0]  sum_q, sum_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  oflow_q, oflow_d;

    logic                  beat;
    logic                  start;
    logic [CNT_WIDTH-1:0]  new_len;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [ACC_WIDTH-1:0]  add_sum;
    logic                  add_sat;

    sat_adder_acc #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .i_acc  (acc_q),
        .i_data (i_data),
        .o_sum  (add_sum),
        .o_sat  (add_sat)
    );

    // HOLD passes downstream ready straight through so a new frame can start
    // in the same cycle the previous total is taken.
    assign o_ready    = (state_q == ST_HOLD) ? i_ready : 1'b1;
    assign beat       = i_valid && o_ready;
    assign new_len    = (i_frame_len == '0) ? CNT_WIDTH'(1) : i_frame_len;
    assign cnt_inc    = cnt_q + 1'b1;
    assign o_valid    = valid_q;
    assign o_sum      = sum_q;
    assign o_count    = count_q;
    assign o_overflow = oflow_q;
    assign o_busy     = (state_q == ST_ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        count_d = count_q;
        oflow_d = oflow_q;
        start   = 1'b0;

        if (i_clear) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: start = beat;
                ST_ACCUM: begin
                    if (beat) begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_sat;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = ST_HOLD;
                            valid_d = 1'b1;
                            sum_d   = add_sum;
                            count_d = len_q;
                            oflow_d = ovf_q | add_sat;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                        start   = beat;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (start) begin
            len_d = new_len;
            acc_d = ACC_WIDTH'(i_data);
            cnt_d = CNT_WIDTH'(1);
            ovf_d = 1'b0;
            if (new_len == CNT_WIDTH'(1)) begin
                state_d = ST_HOLD;
                valid_d = 1'b1;
                sum_d   = ACC_WIDTH'(i_data);
                count_d = CNT_WIDTH'(1);
                oflow_d = 1'b0;
            end else begin
                state_d = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            oflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            oflow_q <= oflow_d;
        end
    end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: default-width DUT with a scoreboard,
// plus a 13-bit accumulator instance for the saturation corners.
module tb_adder_result_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, o_ready, i_clear, o_valid, i_ready, o_overflow, o_busy;
    logic [12:0] i_data;
    logic [3:0]  i_frame_len, o_count;
    logic [19:0] o_sum;

    logic        v2, rdy_o2, clr2, val_o2, rdy2, ovf_o2, busy_o2;
    logic [12:0] d2, sum_o2;
    logic [3:0]  len2, cnt_o2;

    int checks = 0;
    int errors = 0;

    typedef struct { int sum; int cnt; int ovf; } exp_t;
    typedef struct { int len; int nb; int b[4]; int sum; int cnt; int ovf; } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    adder_result_accumulator dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_frame_len(i_frame_len), .i_clear(i_clear),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_count(o_count),
        .o_overflow(o_overflow), .o_busy(o_busy)
    );

    adder_result_accumulator #(.ACC_WIDTH(13)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy_o2),
        .i_data(d2), .i_frame_len(len2), .i_clear(clr2),
        .o_valid(val_o2), .i_ready(rdy2), .o_sum(sum_o2), .o_count(cnt_o2),
        .o_overflow(ovf_o2), .o_busy(busy_o2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer one beat, wait (bounded) for o_ready, return just after acceptance.
    task automatic beat(input int d, input int len);
        int n = 0;
        i_valid = 1'b1; i_data = 13'(d); i_frame_len = 4'(len);
        @(negedge clk);
        while (!o_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic beat2(input int d, input int len);
        v2 = 1'b1; d2 = 13'(d); len2 = 4'(len);
        @(negedge clk);
        chk("sat_ready", int'(rdy_o2), 1);
        @(posedge clk); #1;
        v2 = 1'b0;
    endtask

    task automatic chk_sat(input int s, input int c, input int o);
        chk("sat_valid", int'(val_o2), 1);
        chk("sat_sum", int'(sum_o2), s);
        chk("sat_count", int'(cnt_o2), c);
        chk("sat_ovf", int'(ovf_o2), o);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_sum"}, int'(o_sum), 0);
        chk({tag, "_count"}, int'(o_count), 0);
        chk({tag, "_ovf"}, int'(o_overflow), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_ready"}, int'(o_ready), 1);
    endtask

    // Scoreboard: every output handshake must match the oldest expected frame.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got sum %0d expected no frame", o_sum);
            end else begin
                e = sb.pop_front();
                chk("sb_sum", int'(o_sum), e.sum);
                chk("sb_count", int'(o_count), e.cnt);
                chk("sb_ovf", int'(o_overflow), e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3, 3, '{100, 200, 8191, 0}, 8491, 3, 0};
        vecs[1] = '{0, 1, '{4096, 0, 0, 0}, 4096, 1, 0};
        vecs[2] = '{0, 1, '{7, 0, 0, 0}, 7, 1, 0};
        vecs[3] = '{4, 4, '{10, 20, 30, 40}, 100, 4, 0};
        vecs[4] = '{2, 2, '{0, 0, 0, 0}, 0, 2, 0};
        vecs[5] = '{1, 1, '{8191, 0, 0, 0}, 8191, 1, 0};
        vecs[6] = '{2, 2, '{8191, 8191, 0, 0}, 16382, 2, 0};

        rst = 1'b1; i_valid = 0; i_data = 0; i_frame_len = 0; i_clear = 0; i_ready = 1;
        v2 = 0; d2 = 0; len2 = 0; clr2 = 0; rdy2 = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        chk("reset_sat_valid", int'(val_o2), 0);
        rst = 1'b0;

        // Saturation corners on the 13-bit accumulator.
        beat2(8000, 2); beat2(500, 2); chk_sat(8191, 2, 1);
        beat2(5, 1);                   chk_sat(5, 1, 0);
        beat2(8000, 2); beat2(191, 2); chk_sat(8191, 2, 0);
        beat2(8000, 2); beat2(192, 2); chk_sat(8191, 2, 1);

        // Table-driven frames, back to back with i_ready held high.
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{vecs[i].sum, vecs[i].cnt, vecs[i].ovf});
            for (int k = 0; k < vecs[i].nb; k++) begin
                beat(vecs[i].b[k], vecs[i].len);
                if (k < vecs[i].nb - 1) begin
                    chk("busy_mid", int'(o_busy), 1);
                end else begin
                    chk("valid_latency", int'(o_valid), 1);
                    chk("busy_last", int'(o_busy), 0);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: total held stable, offered beat waits for i_ready.
        i_ready = 1'b0;
        sb.push_back('{3, 2, 0});
        beat(1, 2); beat(2, 2);
        i_valid = 1'b1; i_data = 13'd9; i_frame_len = 4'd1;
        sb.push_back('{9, 1, 0});
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", int'(o_valid), 1);
            chk("bp_sum", int'(o_sum), 3);
            chk("bp_ready", int'(o_ready), 0);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("bp_next_valid", int'(o_valid), 1);
        chk("bp_next_sum", int'(o_sum), 9);
        repeat (2) @(posedge clk);
        #1;

        // Abort a partial frame; beat offered with i_clear is dropped.
        beat(5, 4); beat(6, 4);
        chk("abort_busy_pre", int'(o_busy), 1);
        i_valid = 1'b1; i_data = 13'd50; i_clear = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0; i_valid = 1'b0;
        chk("abort_valid", int'(o_valid), 0);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_sum_kept", int'(o_sum), 9);
        chk("abort_count_kept", int'(o_count), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_output", int'(o_valid), 0);
        sb.push_back('{10, 1, 0});
        beat(10, 1);
        chk("abort_next_sum", int'(o_sum), 10);
        chk("abort_next_count", int'(o_count), 1);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-ACCUM, then reset while holding an untaken total.
        beat(7, 3);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk_zero("rst_accum");
        i_ready = 1'b0;
        beat(33, 1);
        chk("hold_valid", int'(o_valid), 1);
        chk("hold_sum", int'(o_sum), 33);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk_zero("rst_hold");
        i_ready = 1'b1;
        sb.push_back('{9, 2, 0});
        beat(4, 2); beat(5, 2);
        chk("post_rst_valid", int'(o_valid), 1);

        // Longest frame of max-value samples.
        sb.push_back('{122865, 15, 0});
        for (int k = 0; k < 15; k++) beat(8191, 15);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
